// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmitter.
// No ports. The package provides the FSM state enum, the encoder line-mode
// enum, the packet framing constants, the line-state encodings
// ({d_plus, d_minus}) and a helper that builds the PID byte.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  // What the encoder drives at the start of the next bit period.
  typedef enum logic [1:0] {
    MODE_DATA,
    MODE_SE0,
    MODE_J
  } line_mode_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [7:0] pid_byte(input logic [3:0] p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// Line encoder for the USB transmitter: bit timer, NRZI line register and
// bit stuffing.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            a packet is in progress (timer and ones counter run)
//   mode          what to put on the line at the next bit start
//   bit_in        data bit to send when bit_req is high
//   bit_req       this cycle ends a bit period and bit_in is consumed at the edge
//   d_plus/d_minus registered line outputs
// bit_req stays low at the end of the bit that completes a run of
// STUFF_LIMIT ones; the stuffed 0 goes out in that slot instead.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  line_mode_t mode,
  input  logic       bit_in,
  output logic       bit_req,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    ones;
  logic [1:0]    line_q;
  logic          tick;
  logic          stuff;

  // cnt sits at zero while idle, so the first bit starts one cycle after en rises.
  assign tick    = en && (cnt == '0);
  assign stuff   = (ones == 3'(STUFF_LIMIT));
  assign bit_req = tick && !stuff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ones   <= '0;
      line_q <= LINE_J;
    end else if (!en) begin
      cnt  <= '0;
      ones <= '0;
    end else if (tick) begin
      cnt <= CNT_LOAD;
      case (mode)
        MODE_SE0: begin
          line_q <= LINE_SE0;
          ones   <= '0;
        end
        MODE_J: begin
          line_q <= LINE_J;
          ones   <= '0;
        end
        default: begin
          // A stuffed bit or a data 0 toggles the line; a data 1 holds it.
          if (stuff || !bit_in) begin
            line_q <= (line_q == LINE_J) ? LINE_K : LINE_J;
            ones   <= '0;
          end else begin
            ones <= ones + 3'd1;
          end
        end
      endcase
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign d_plus  = line_q[1];
  assign d_minus = line_q[0];

endmodule

// File: rtl/usb_transmitter.sv
// USB full-speed-style packet transmitter. Sends SYNC, PID, zero or more
// bytes from a show-ahead TX FIFO, then EOP, NRZI-encoded with bit stuffing.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, pid            packet request (taken in IDLE only) and PID nibble
//   fifo_empty, fifo_data show-ahead TX FIFO head
//   fifo_rd               pop; fifo_data is captured on the same edge
//   busy, done            packet in progress, completion pulse
//   d_plus, d_minus       registered bus lines
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | line J, waiting for start
// ST_SYNC    | shifting out the SYNC byte
// ST_PID     | shifting out {~pid, pid}
// ST_DATA    | shifting out a FIFO byte
// ST_EOP_SE0 | two bit times of SE0
// ST_EOP_J   | one bit time of J, then done
module usb_transmitter
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       busy,
  output logic       done,
  output logic       d_plus,
  output logic       d_minus
);

  tx_state_t  state, state_nxt;
  logic [7:0] shifter, shifter_nxt;
  logic [3:0] pid_q, pid_nxt;
  logic [3:0] bits_left, bits_left_nxt;
  logic [7:0] new_byte;
  logic       load;
  logic       leave;
  logic       bit_req;
  logic       bit_in;
  line_mode_t mode;

  usb_tx_encoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_enc (
    .clk     (clk),
    .rst     (rst),
    .en      (state != ST_IDLE),
    .mode    (mode),
    .bit_in  (bit_in),
    .bit_req (bit_req),
    .d_plus  (d_plus),
    .d_minus (d_minus)
  );

  // bits_left == 0 on a bit_req means the current byte's last bit has just
  // finished its period: that cycle is the byte boundary, and the first bit
  // of the next byte (or SE0) goes out on its closing edge.
  always_comb begin
    state_nxt     = state;
    shifter_nxt   = shifter;
    pid_nxt       = pid_q;
    bits_left_nxt = bits_left;
    new_byte      = shifter;
    load          = 1'b0;
    bit_in        = 1'b1;
    fifo_rd       = 1'b0;
    leave         = 1'b0;
    case (state)
      ST_IDLE: begin
        // done is high in the cycle right after a packet; start is ignored there.
        if (start && !done) begin
          pid_nxt       = pid;
          shifter_nxt   = SYNC_BYTE;
          bits_left_nxt = 4'd8;
          state_nxt     = ST_SYNC;
        end
      end
      ST_SYNC, ST_PID, ST_DATA: begin
        if (bit_req) begin
          if (bits_left != 4'd0) begin
            bit_in        = shifter[0];
            shifter_nxt   = {1'b0, shifter[7:1]};
            bits_left_nxt = bits_left - 4'd1;
          end else if (state == ST_SYNC) begin
            new_byte  = pid_byte(pid_q);
            load      = 1'b1;
            state_nxt = ST_PID;
          end else if (!fifo_empty) begin
            new_byte  = fifo_data;
            load      = 1'b1;
            fifo_rd   = 1'b1;
            state_nxt = ST_DATA;
          end else begin
            bits_left_nxt = 4'(EOP_SE0_BITS - 1);
            state_nxt     = ST_EOP_SE0;
          end
          if (load) begin
            bit_in        = new_byte[0];
            shifter_nxt   = {1'b0, new_byte[7:1]};
            bits_left_nxt = 4'd7;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_req) begin
          if (bits_left != 4'd0) bits_left_nxt = bits_left - 4'd1;
          else                   state_nxt     = ST_EOP_J;
        end
      end
      ST_EOP_J: begin
        if (bit_req) begin
          state_nxt = ST_IDLE;
          leave     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The mode follows the state being entered so SE0/J start on the same edge
  // as the transition.
  always_comb begin
    case (state_nxt)
      ST_EOP_SE0:       mode = MODE_SE0;
      ST_EOP_J, ST_IDLE: mode = MODE_J;
      default:          mode = MODE_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shifter   <= '0;
      pid_q     <= '0;
      bits_left <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shifter   <= shifter_nxt;
      pid_q     <= pid_nxt;
      bits_left <= bits_left_nxt;
      // busy lags the state by one edge so it rises with the first SYNC bit.
      busy      <= (state != ST_IDLE) && !leave;
      done      <= leave;
    end
  end

endmodule

// File: tb/tb_usb_transmitter.sv
// Directed bench for usb_transmitter: drives packets from a FIFO model,
// decodes the line (NRZI, destuffing, EOP) and checks timing and contents.
module tb_usb_transmitter;

  localparam int CPB     = 8;
  localparam int TIMEOUT = CPB * 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pid = 4'h0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, busy, done, d_plus, d_minus;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_bad = 0;

  usb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pid        (pid),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .busy       (busy),
    .done       (done),
    .d_plus     (d_plus),
    .d_minus    (d_minus)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model; pops on an edge where fifo_rd is high.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Pushes n bytes, lowest byte of b first, into the FIFO and the expectation list.
  task automatic push_bytes(input int n, input logic [23:0] b);
    logic [23:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      fq.push_back(v[7:0]);
      exp_q.push_back(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic run_packet(input string tag, input logic [3:0] p, input logic [7:0] exp_pid,
                            input int exp_s, input bit exp_stuff_end,
                            input bit poke_busy, input bit poke_done);
    int cyc, nrd, nbits, ones, nstuff, viol, nse0, n_data, exp_bits;
    bit got_done, last_stuff, in_eop, b;
    logic [1:0] prev;
    logic [7:0] cur;
    logic [1:0] sym[$];
    logic [7:0] dec[$];
    cyc = 0; nrd = 0; nbits = 0; ones = 0; nstuff = 0; viol = 0; nse0 = 0;
    got_done = 0; last_stuff = 0; in_eop = 0; cur = 8'h00; prev = 2'b10;
    n_data   = exp_q.size();
    exp_bits = 19 + 8 * n_data + exp_s;

    start = 1'b1; pid = p;
    @(posedge clk); #1;
    start = 1'b0; pid = ~p;
    chk({tag, "/busy_k"}, busy, 1'b0);
    chk({tag, "/line_k"}, {d_plus, d_minus}, 2'b10);
    while (!got_done && cyc < TIMEOUT) begin
      @(negedge clk);
      if (fifo_rd) nrd++;
      if (cyc >= 1 && ((cyc - 1) % CPB) == CPB / 2) sym.push_back({d_plus, d_minus});
      @(posedge clk); #1;
      cyc++;
      start = poke_busy && (cyc == 40);
      if (cyc == 1) begin
        chk({tag, "/busy_k1"}, busy, 1'b1);
        chk({tag, "/first_k"}, {d_plus, d_minus}, 2'b01);
      end
      if (done) got_done = 1;
    end
    chk({tag, "/done_seen"}, got_done, 1'b1);
    chk({tag, "/dur"}, cyc, CPB * exp_bits + 1);
    chk({tag, "/busy_end"}, busy, 1'b0);
    if (poke_done) begin
      start = 1'b1; pid = 4'hF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/done_pulse"}, done, 1'b0);
    if (poke_done) begin
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "/start_on_done_ignored"}, busy, 1'b0);
    end

    foreach (sym[i]) begin
      if (sym[i] == 2'b00) begin
        nse0++;
        in_eop = 1;
      end else if (!in_eop) begin
        b = (sym[i] == prev);
        prev = sym[i];
        if (ones == 6) begin
          if (b) viol++;
          nstuff++;
          ones = 0;
          last_stuff = 1;
        end else begin
          last_stuff = 0;
          ones = b ? ones + 1 : 0;
          cur = {b, cur[7:1]};
          nbits++;
          if (nbits % 8 == 0) dec.push_back(cur);
        end
      end
    end
    chk({tag, "/nsym"}, sym.size(), exp_bits);
    chk({tag, "/fifo_rd_cnt"}, nrd, n_data);
    chk({tag, "/fifo_left"}, fq.size(), 0);
    chk({tag, "/nbytes"}, dec.size(), n_data + 2);
    chk({tag, "/odd_bits"}, nbits % 8, 0);
    if (dec.size() >= 2) begin
      chk({tag, "/sync"}, dec[0], 8'h80);
      chk({tag, "/pid"}, dec[1], exp_pid);
    end
    foreach (exp_q[i]) begin
      if (i + 2 < dec.size()) chk({tag, "/data"}, dec[i + 2], exp_q[i]);
    end
    chk({tag, "/nstuff"}, nstuff, exp_s);
    chk({tag, "/stuff_viol"}, viol, 0);
    chk({tag, "/se0_bits"}, nse0, 2);
    chk({tag, "/stuff_before_eop"}, last_stuff, exp_stuff_end);
    if (sym.size() > 0) chk({tag, "/eop_j"}, sym[sym.size() - 1], 2'b10);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dp", d_plus, 1'b1);
    chk("rst_dm", d_minus, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_packet("empty", 4'b0001, 8'hE1, 0, 0, 0, 0);
    push_bytes(3, 24'h614000);
    run_packet("three", 4'b0001, 8'hE1, 0, 0, 0, 0);
    push_bytes(3, 24'hCFF7FF);
    run_packet("stuff", 4'b1011, 8'h4B, 2, 0, 0, 0);
    push_bytes(1, 24'h0000FC);
    run_packet("stuff_eop", 4'b0001, 8'hE1, 1, 1, 0, 0);
    push_bytes(1, 24'h000012);
    run_packet("poke", 4'b0011, 8'hC3, 0, 0, 1, 1);
    run_packet("b2b_a", 4'b1001, 8'h69, 0, 0, 0, 0);
    push_bytes(1, 24'h0000A5);
    run_packet("b2b_b", 4'b0101, 8'hA5, 0, 0, 0, 0);

    // Reset in the middle of a run of ones inside the data bytes.
    fq.push_back(8'hFF);
    fq.push_back(8'hFF);
    start = 1'b1; pid = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (CPB * 28) @(posedge clk);
    @(negedge clk);
    #2;
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_line", {d_plus, d_minus}, 2'b10);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd", fifo_rd, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_hold", {d_plus, d_minus}, 2'b10);
    rst = 1'b0;
    fq.delete();
    repeat (3) @(posedge clk);
    #1;
    push_bytes(3, 24'hCFF7FF);
    run_packet("after_rst", 4'b1011, 8'h4B, 2, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
